dcache_sram_nway: RTL and testbench



---
 rtl/dcache_sram_nway.sv | 142 ++++++++++++++
 tb/tb_dcache_sram_nway.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_sram_nway.sv
// N-way set-associative tag/data array with true-LRU ages, per-line dirty bits
// and a self-timed flush engine that writes back dirty lines over valid/ready.
module dcache_sram_nway #(
  parameter int SETS   = 16,
  parameter int WAYS   = 2,
  parameter int TAG_W  = 23,
  parameter int LINE_W = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic                    write_i,
  input  logic [$clog2(SETS)-1:0] addr_i,
  input  logic [TAG_W-1:0]        tag_i,
  input  logic [LINE_W-1:0]       data_i,
  input  logic                    dirty_i,
  input  logic                    flush_i,
  output logic [TAG_W+1:0]        tag_o,
  output logic [LINE_W-1:0]       data_o,
  output logic                    hit_o,
  output logic                    busy_o,
  output logic                    wb_valid_o,
  input  logic                    wb_ready_i,
  output logic [$clog2(SETS)-1:0] wb_set_o,
  output logic [TAG_W-1:0]        wb_tag_o,
  output logic [LINE_W-1:0]       wb_data_o,
  output logic                    flush_done_o
);
  localparam int SET_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} state_e;

  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic              valid_q [SETS][WAYS];
  logic              dirty_q [SETS][WAYS];
  logic [WAY_W-1:0]  age_q   [SETS][WAYS];

  state_e                   state_q;
  logic [SET_W+WAY_W-1:0]   ptr_q;
  logic [SET_W-1:0]         ptr_set;
  logic [WAY_W-1:0]         ptr_way;

  logic             hit_any, inv_any;
  logic [WAY_W-1:0] hit_way, inv_way, lru_way, sel_way, tgt_age;

  // The line pointer walks set-major; WAYS is a power of two so {set, way} is one counter.
  assign ptr_set = ptr_q[SET_W+WAY_W-1:WAY_W];
  assign ptr_way = ptr_q[WAY_W-1:0];

  // NOTE: every variable gets a default before the loops so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    lru_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (valid_q[addr_i][w] && tag_q[addr_i][w] == tag_i) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[addr_i][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
      if (age_q[addr_i][w] == WAY_W'(WAYS-1)) lru_way = WAY_W'(w);
    end
    sel_way = hit_any ? hit_way : (inv_any ? inv_way : lru_way);
    tgt_age = age_q[addr_i][sel_way];
  end

  assign hit_o        = hit_any && (state_q == IDLE);
  assign tag_o        = {valid_q[addr_i][sel_way], dirty_q[addr_i][sel_way], tag_q[addr_i][sel_way]};
  assign data_o       = data_q[addr_i][sel_way];
  assign busy_o       = (state_q != IDLE);
  assign wb_valid_o   = (state_q == WB);
  assign flush_done_o = (state_q == DONE);
  assign wb_set_o     = wb_valid_o ? ptr_set : '0;
  assign wb_tag_o     = wb_valid_o ? tag_q[ptr_set][ptr_way] : '0;
  assign wb_data_o    = wb_valid_o ? data_q[ptr_set][ptr_way] : '0;

  // NOTE: state uses <= throughout so every read in this block sees the pre-edge value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the arrays are flops, not a macro, so they take the async clear like any other state.
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]   <= '0;
          data_q[s][w]  <= '0;
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= WAY_W'(w);
        end
      end
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable_i && (write_i || hit_any)) begin
            for (int w = 0; w < WAYS; w++) begin
              if (WAY_W'(w) == sel_way) age_q[addr_i][w] <= '0;
              else if (age_q[addr_i][w] < tgt_age) age_q[addr_i][w] <= age_q[addr_i][w] + 1'b1;
            end
          end
          if (enable_i && write_i) begin
            tag_q[addr_i][sel_way]   <= tag_i;
            data_q[addr_i][sel_way]  <= data_i;
            valid_q[addr_i][sel_way] <= 1'b1;
            dirty_q[addr_i][sel_way] <= dirty_i;
          end
          if (flush_i) begin
            state_q <= SCAN;
            ptr_q   <= '0;
          end
        end
        SCAN: begin
          if (valid_q[ptr_set][ptr_way] && dirty_q[ptr_set][ptr_way]) begin
            state_q <= WB;
          end else begin
            valid_q[ptr_set][ptr_way] <= 1'b0;
            dirty_q[ptr_set][ptr_way] <= 1'b0;
            ptr_q <= ptr_q + 1'b1;
            if (&ptr_q) state_q <= DONE;
          end
        end
        WB: begin
          if (wb_ready_i) begin
            valid_q[ptr_set][ptr_way] <= 1'b0;
            dirty_q[ptr_set][ptr_way] <= 1'b0;
            ptr_q   <= ptr_q + 1'b1;
            state_q <= (&ptr_q) ? DONE : SCAN;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_sram_nway.sv
// Drives a 2-way and a 4-way instance with the same accesses and compares both
// against a recency-list reference model, including flush write-back sequencing.
module tb_dcache_sram_nway;
  localparam int SETS = 16, TAG_W = 23, LINE_W = 256;
  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [LINE_W-1:0] line_t;

  logic clk_i = 1'b0, rst_ni = 1'b0, enable_i = 1'b0, write_i = 1'b0;
  logic dirty_i = 1'b0, flush_i = 1'b0;
  logic [3:0] addr_i = '0;
  tag_t  tag_i  = '0;
  line_t data_i = '0;

  logic       wb_ready [2];
  logic [TAG_W+1:0] tag_w [2];
  line_t      data_w [2], wb_data_w [2];
  logic       hit_w [2], busy_w [2], wb_valid_w [2], done_w [2];
  logic [3:0] wb_set_w [2];
  tag_t       wb_tag_w [2];

  int n_checks = 0, n_fail = 0;

  always #5 clk_i = ~clk_i;

  dcache_sram_nway #(.SETS(SETS), .WAYS(2), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .write_i(write_i), .addr_i(addr_i),
    .tag_i(tag_i), .data_i(data_i), .dirty_i(dirty_i), .flush_i(flush_i), .tag_o(tag_w[0]),
    .data_o(data_w[0]), .hit_o(hit_w[0]), .busy_o(busy_w[0]), .wb_valid_o(wb_valid_w[0]),
    .wb_ready_i(wb_ready[0]), .wb_set_o(wb_set_w[0]), .wb_tag_o(wb_tag_w[0]),
    .wb_data_o(wb_data_w[0]), .flush_done_o(done_w[0]));

  dcache_sram_nway #(.SETS(SETS), .WAYS(4), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .write_i(write_i), .addr_i(addr_i),
    .tag_i(tag_i), .data_i(data_i), .dirty_i(dirty_i), .flush_i(flush_i), .tag_o(tag_w[1]),
    .data_o(data_w[1]), .hit_o(hit_w[1]), .busy_o(busy_w[1]), .wb_valid_o(wb_valid_w[1]),
    .wb_ready_i(wb_ready[1]), .wb_set_o(wb_set_w[1]), .wb_tag_o(wb_tag_w[1]),
    .wb_data_o(wb_data_w[1]), .flush_done_o(done_w[1]));

  // Reference model: ord[m][s] lists ways from most to least recently used.
  bit    mv   [2][SETS][4];
  bit    md   [2][SETS][4];
  tag_t  mt   [2][SETS][4];
  line_t mdat [2][SETS][4];
  int    ord  [2][SETS][4];

  function automatic int wof(input int m);
    return (m == 0) ? 2 : 4;
  endfunction

  task automatic check(input string name, input logic [LINE_W+31:0] got, input logic [LINE_W+31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++)
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < 4; w++) begin
          mv[m][s][w] = 0; md[m][s][w] = 0; mt[m][s][w] = '0; mdat[m][s][w] = '0;
          ord[m][s][w] = w;
        end
  endfunction

  function automatic int m_hit(input int m, input int s, input tag_t t);
    for (int w = 0; w < wof(m); w++)
      if (mv[m][s][w] && mt[m][s][w] == t) return w;
    return -1;
  endfunction

  function automatic int m_victim(input int m, input int s);
    for (int w = 0; w < wof(m); w++)
      if (!mv[m][s][w]) return w;
    return ord[m][s][wof(m)-1];
  endfunction

  function automatic void m_touch(input int m, input int s, input int w);
    int p = 0;
    for (int i = 0; i < wof(m); i++) if (ord[m][s][i] == w) p = i;
    for (int i = p; i > 0; i--) ord[m][s][i] = ord[m][s][i-1];
    ord[m][s][0] = w;
  endfunction

  function automatic line_t rand_line();
    line_t r;
    for (int i = 0; i < LINE_W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Entered just after a rising edge; leaves just after the edge that commits the access.
  task automatic access(input bit wr, input int s, input tag_t t, input line_t d, input bit dty, input bit fl);
    enable_i = 1'b1; write_i = wr; addr_i = 4'(s); tag_i = t; data_i = d; dirty_i = dty; flush_i = fl;
    @(negedge clk_i);
    for (int m = 0; m < 2; m++) begin
      int h = m_hit(m, s, t);
      int sw = (h >= 0) ? h : m_victim(m, s);
      check($sformatf("hit%0d s%0d t%0h", m, s, t), hit_w[m], (h >= 0));
      check($sformatf("tag_o%0d s%0d t%0h", m, s, t), tag_w[m], {mv[m][s][sw], md[m][s][sw], mt[m][s][sw]});
      check($sformatf("data_o%0d s%0d t%0h", m, s, t), data_w[m], mdat[m][s][sw]);
      if (wr || h >= 0) m_touch(m, s, sw);
      if (wr) begin
        mv[m][s][sw] = 1; md[m][s][sw] = dty; mt[m][s][sw] = t; mdat[m][s][sw] = d;
      end
    end
    @(posedge clk_i); #1;
    enable_i = 1'b0; write_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic flush_mon(input int m, input int stall_first);
    logic [3:0] es [64];
    tag_t  et [64];
    line_t ed [64];
    int n = 0, hs = 0, stall = 0, busy_cyc = 0, dones = 0;
    bit timeout = 1;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < wof(m); w++)
        if (mv[m][s][w] && md[m][s][w]) begin
          es[n] = 4'(s); et[n] = mt[m][s][w]; ed[n] = mdat[m][s][w]; n++;
        end
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk_i);
      wb_ready[m] = 1'b0;
      if (!busy_w[m]) begin timeout = 0; break; end
      busy_cyc++;
      if (done_w[m]) dones++;
      check($sformatf("hit_busy%0d", m), hit_w[m], 1'b0);
      if (wb_valid_w[m]) begin
        if (hs < n) begin
          check($sformatf("wb_set%0d #%0d", m, hs), wb_set_w[m], es[hs]);
          check($sformatf("wb_tag%0d #%0d", m, hs), wb_tag_w[m], et[hs]);
          check($sformatf("wb_data%0d #%0d", m, hs), wb_data_w[m], ed[hs]);
        end
        if (hs == 0 && stall < stall_first) stall++;
        else begin wb_ready[m] = 1'b1; hs++; end
      end
    end
    check($sformatf("flush_timeout%0d", m), timeout, 1'b0);
    check($sformatf("flush_busy_cycles%0d", m), busy_cyc, SETS*wof(m) + 1 + n + stall);
    check($sformatf("flush_done_pulses%0d", m), dones, 1);
    check($sformatf("flush_handshakes%0d", m), hs, n);
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < 4; w++) begin mv[m][s][w] = 0; md[m][s][w] = 0; end
  endtask

  task automatic run_flush(input int stall);
    fork
      flush_mon(0, stall);
      flush_mon(1, stall);
    join
    @(posedge clk_i); #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk_i); rst_ni = 1'b0;
    model_reset();
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  initial begin
    int seen, dones;
    line_t d;
    wb_ready[0] = 1'b0; wb_ready[1] = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("rst_hit%0d", m), hit_w[m], 1'b0);
      check($sformatf("rst_tag%0d", m), tag_w[m], '0);
      check($sformatf("rst_data%0d", m), data_w[m], '0);
      check($sformatf("rst_busy%0d", m), busy_w[m], 1'b0);
      check($sformatf("rst_wbv%0d", m), wb_valid_w[m], 1'b0);
      check($sformatf("rst_done%0d", m), done_w[m], 1'b0);
      check($sformatf("rst_wb%0d", m), {wb_set_w[m], wb_tag_w[m], wb_data_w[m]}, '0);
    end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Miss, fill, hit on set 3.
    d = rand_line();
    access(0, 3, 23'h15, '0, 0, 0);
    access(1, 3, 23'h15, d, 0, 0);
    access(0, 3, 23'h15, '0, 0, 0);

    // Dirty write hit on way 1 of set 2, then a miss exposes the LRU victim.
    access(1, 2, 23'h100, rand_line(), 0, 0);
    access(1, 2, 23'h200, rand_line(), 0, 0);
    access(1, 2, 23'h200, rand_line(), 1, 0);
    access(0, 2, 23'h200, '0, 0, 0);
    access(0, 2, 23'h300, '0, 0, 0);

    // LRU replacement on set 5.
    for (int i = 0; i < 4; i++) access(1, 5, tag_t'(23'hA0 + 16*i), rand_line(), 0, 0);
    access(0, 5, 23'hA0, '0, 0, 0);
    access(1, 5, 23'hE0, rand_line(), 0, 0);
    for (int i = 0; i < 5; i++) access(0, 5, tag_t'(23'hA0 + 16*((i + 1) % 5)), '0, 0, 0);

    // Two dirty lines (set 0 way 1, set 7 way 0), first write-back stalled 3 cycles.
    pulse_reset();
    access(1, 0, 23'h11, rand_line(), 0, 0);
    access(1, 0, 23'h22, rand_line(), 1, 0);
    access(1, 7, 23'h33, rand_line(), 1, 1);
    run_flush(3);
    access(0, 0, 23'h11, '0, 0, 0);
    access(0, 0, 23'h22, '0, 0, 0);
    access(0, 7, 23'h33, '0, 0, 0);

    // Clean-cache flush.
    access(0, 1, 23'h5, '0, 0, 1);
    run_flush(0);

    // Randomized traffic with periodic flushes.
    for (int i = 0; i < 240; i++) begin
      bit fl = (i % 60 == 59);
      access(1'($urandom), $urandom_range(0, 3), tag_t'($urandom_range(1, 6)), rand_line(),
             1'($urandom), fl);
      if (fl) run_flush($urandom_range(0, 2));
    end

    // Reset in the middle of a write-back.
    access(1, 9, 23'h77, rand_line(), 1, 0);
    access(0, 9, 23'h77, '0, 0, 1);
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_i);
      if (wb_valid_w[0]) begin seen = 1; break; end
    end
    check("wb_reached", seen, 1);
    #2 rst_ni = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("mid_rst_wbv%0d", m), wb_valid_w[m], 1'b0);
      check($sformatf("mid_rst_busy%0d", m), busy_w[m], 1'b0);
    end
    model_reset();
    dones = 0;
    repeat (2) begin @(negedge clk_i); dones += done_w[0] + done_w[1]; end
    rst_ni = 1'b1;
    repeat (3) begin @(negedge clk_i); dones += done_w[0] + done_w[1] + busy_w[0] + busy_w[1]; end
    check("no_done_after_rst", dones, 0);
    @(posedge clk_i); #1;
    access(0, 9, 23'h77, '0, 0, 0);
    access(0, 3, 23'h15, '0, 0, 0);
    access(0, 0, 23'h0, '0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
